ethernet_rx_drain: RTL and testbench

Drains completed frames out of the Ethernet receive packet buffer and re-emits them as a ready/valid word stream with byte-keep and last markers. Sits directly downstream of the receive side of the MAC-with-buffer wrapper, on the same logic clock. It polls `packet_avail`, reads every word of the frame through the buffer's read port, and acknowledges the frame once the consumer has taken the final word.

---
 rtl/ethernet_pkg.sv | 27 ++
 rtl/ethernet_rx_drain_fifo.sv | 50 +++++
 rtl/ethernet_rx_drain.sv | 130 +++++++++++++
 tb/tb_ethernet_rx_drain.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_pkg.sv
// Shared types and helpers for the Ethernet receive-drain datapath.
// Holds the drain FSM state encoding and the byte-keep mask builder.
package ethernet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ACK   = 2'd3
  } eth_rx_drain_state_e;

  localparam int unsigned KEEP_MAX_W = 128;

  // Low-order keep mask: a remainder of 0 means the whole word is valid.
  function automatic logic [KEEP_MAX_W-1:0] eth_keep_mask(input int unsigned rem,
                                                          input int unsigned nbytes);
    logic [KEEP_MAX_W-1:0] m;
    int unsigned n;
    n = (rem == 0) ? nbytes : rem;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/ethernet_rx_drain_fifo.sv
// Two-entry FIFO with a registered head; the head register drives the output stream
// directly, so the stream holds steady whenever it is not popped.
module eth_rx_drain_fifo
  import ethernet_pkg::*;
#(
  parameter int unsigned width_p = 37
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] r_head;
  logic [width_p-1:0] r_tail;
  logic [1:0]         r_count;
  logic               w_pop;

  assign w_pop = pop_i & (r_count != 2'd0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_count <= '0;
    end else begin
      if (push_i && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
        r_head <= data_i;
      end else if (w_pop && (r_count == 2'd2)) begin
        r_head <= r_tail;
      end
      r_count <= r_count + {1'b0, push_i} - {1'b0, w_pop};
    end
  end

  // Second slot only ever feeds the head, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && (((r_count == 2'd1) && !w_pop) || ((r_count == 2'd2) && w_pop))) begin
      r_tail <= data_i;
    end
  end

  assign data_o  = r_head;
  assign v_o     = (r_count != 2'd0);
  assign count_o = r_count;

endmodule

// File: rtl/ethernet_rx_drain.sv
// Drains complete frames from the receive packet buffer into a ready/valid word
// stream with keep/last, acknowledging each frame after its final word is taken.
module ethernet_rx_drain
  import ethernet_pkg::*;
#(
  parameter int unsigned eth_mtu_p    = 2048,
  parameter int unsigned data_width_p = 32,
  localparam int unsigned bytes_lp             = data_width_p / 8,
  localparam int unsigned addr_width_lp        = $clog2(eth_mtu_p),
  localparam int unsigned packet_size_width_lp = $clog2(eth_mtu_p + 1),
  localparam int unsigned size_width_lp        = $clog2(((bytes_lp == 1) ? 1 : $clog2(bytes_lp)) + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            packet_avail_i,
  input  logic [packet_size_width_lp-1:0] packet_rsize_i,
  output logic                            packet_ack_o,
  output logic                            packet_rvalid_o,
  output logic [addr_width_lp-1:0]        packet_raddr_o,
  output logic [size_width_lp-1:0]        packet_rdata_size_o,
  input  logic [data_width_p-1:0]         packet_rdata_i,
  output logic [data_width_p-1:0]         data_o,
  output logic [bytes_lp-1:0]             keep_o,
  output logic                            last_o,
  output logic                            v_o,
  input  logic                            ready_i,
  output logic [15:0]                     drained_count_o
);

  localparam int unsigned pw_lp       = packet_size_width_lp;
  localparam int unsigned lg_bytes_lp = $clog2(bytes_lp);
  localparam int unsigned fifo_w_lp   = data_width_p + bytes_lp + 1;

  function automatic logic [pw_lp-1:0] sat_size(input logic [pw_lp-1:0] s);
    return (s > pw_lp'(eth_mtu_p)) ? pw_lp'(eth_mtu_p) : s;
  endfunction

  eth_rx_drain_state_e r_state, w_state_n;
  logic [pw_lp-1:0]    r_size;
  logic [pw_lp-1:0]    r_words;
  logic [pw_lp-1:0]    r_rd_idx;
  logic                r_inflight;
  logic                r_inflight_last;
  logic [15:0]         r_count;

  logic [pw_lp-1:0]     w_size_sat;
  logic [pw_lp:0]       w_words_full;
  logic                 w_last_idx;
  logic [1:0]           w_occ;
  logic                 w_xfer;
  logic                 w_room;
  logic                 w_issue;
  logic [bytes_lp-1:0]  w_keep_last;
  logic [bytes_lp-1:0]  w_keep_in;
  logic [fifo_w_lp-1:0] w_head;

  assign w_size_sat   = sat_size(packet_rsize_i);
  assign w_words_full = ({1'b0, w_size_sat} + (pw_lp + 1)'(bytes_lp - 1)) >> lg_bytes_lp;
  assign w_last_idx   = (r_rd_idx == (r_words - pw_lp'(1)));
  assign w_xfer       = v_o & ready_i;

  // Words buffered plus in flight, net of this cycle's pop, must leave a free slot.
  assign w_room  = (({1'b0, w_occ} + {2'b0, r_inflight}) - {2'b0, w_xfer}) < 3'd2;
  assign w_issue = (r_state == ST_READ) & w_room;

  assign w_keep_last = bytes_lp'(eth_keep_mask(32'(r_size) % bytes_lp, bytes_lp));
  assign w_keep_in   = r_inflight_last ? w_keep_last : {bytes_lp{1'b1}};

  always_comb begin
    w_state_n    = r_state;
    packet_ack_o = 1'b0;
    case (r_state)
      ST_IDLE:  if (packet_avail_i) w_state_n = (w_size_sat == '0) ? ST_ACK : ST_READ;
      ST_READ:  if (w_issue && w_last_idx) w_state_n = ST_FLUSH;
      ST_FLUSH: if (w_xfer && last_o) w_state_n = ST_ACK;
      ST_ACK: begin
        w_state_n    = ST_IDLE;
        packet_ack_o = 1'b1;
      end
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= ST_IDLE;
      r_size          <= '0;
      r_words         <= '0;
      r_rd_idx        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state         <= w_state_n;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_idx;
      if ((r_state == ST_IDLE) && packet_avail_i) begin
        r_size   <= w_size_sat;
        r_words  <= pw_lp'(w_words_full);
        r_rd_idx <= '0;
      end else if (w_issue) begin
        r_rd_idx <= r_rd_idx + pw_lp'(1);
      end
      if (r_state == ST_ACK) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  eth_rx_drain_fifo #(
    .width_p (fifo_w_lp)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (r_inflight),
    .data_i    ({packet_rdata_i, w_keep_in, r_inflight_last}),
    .pop_i     (ready_i),
    .data_o    (w_head),
    .v_o       (v_o),
    .count_o   (w_occ)
  );

  assign {data_o, keep_o, last_o} = w_head;

  assign packet_rvalid_o     = w_issue;
  assign packet_raddr_o      = addr_width_lp'(r_rd_idx) << lg_bytes_lp;
  assign packet_rdata_size_o = size_width_lp'(lg_bytes_lp);
  assign drained_count_o     = r_count;

endmodule

// File: tb/tb_ethernet_rx_drain.sv
// Bench for ethernet_rx_drain: models the receive buffer and the expected word stream
// per frame, and checks addresses, words, keep/last, backpressure, ack, count and reset.
module tb_ethernet_rx_drain;

  localparam int MTU = 2048;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        avail;
  logic [11:0] rsize;
  logic        ack;
  logic        rvalid;
  logic [10:0] raddr;
  logic [1:0]  rdsize;
  logic [31:0] rdata;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        last;
  logic        v;
  logic        ready;
  logic [15:0] count;

  always #5 clk = ~clk;

  ethernet_rx_drain #(
    .eth_mtu_p    (MTU),
    .data_width_p (32)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .packet_avail_i      (avail),
    .packet_rsize_i      (rsize),
    .packet_ack_o        (ack),
    .packet_rvalid_o     (rvalid),
    .packet_raddr_o      (raddr),
    .packet_rdata_size_o (rdsize),
    .packet_rdata_i      (rdata),
    .data_o              (data),
    .keep_o              (keep),
    .last_o              (last),
    .v_o                 (v),
    .ready_i             (ready),
    .drained_count_o     (count)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fmem [512];
  logic [36:0] expq [$];
  int          exp_words, exp_rd_idx, issued, consumed;
  logic        prev_rvalid;
  logic [10:0] prev_raddr;
  logic        hold_prev;
  logic [36:0] held;
  logic        last_xfer_prev, zero_due;
  logic [15:0] exp_count;
  int          ready_mode, cyc, acks;
  bit          light, hold_avail, ack_seen;
  logic [3:0]  last_keep_seen;
  bit          bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive buffer read data and ready after the edge, sample at the falling edge.
  task automatic tick();
    logic        exp_ack;
    logic        xfer;
    logic [36:0] e;
    @(posedge clk);
    #1;
    cyc++;
    rdata = prev_rvalid ? fmem[prev_raddr[10:2]] : $urandom;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = bp_pat[cyc % 6];
      default: ready = ($urandom_range(0, 3) != 0);
    endcase
    @(negedge clk);
    ack_seen = ack;
    if (light) begin
      if (ack) acks++;
      prev_rvalid = 1'b0;
    end else begin
      exp_ack  = last_xfer_prev | zero_due;
      zero_due = 1'b0;
      chk("ack", ack, exp_ack);
      chk("count", count, exp_count);
      if (exp_ack) exp_count++;
      if (rvalid) begin
        chk("rd_in_frame", exp_rd_idx < exp_words, 1);
        chk("raddr", raddr, exp_rd_idx * 4);
        chk("rdsize", rdsize, 2);
        exp_rd_idx++;
        issued++;
      end
      prev_rvalid = rvalid;
      prev_raddr  = raddr;
      if (hold_prev) begin
        chk("hold_v", v, 1);
        chk("hold_word", {data, keep, last}, held);
      end
      xfer           = v & ready;
      last_xfer_prev = 1'b0;
      if (xfer) begin
        consumed++;
        chk("word_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("word", {data, keep, last}, e);
          last_xfer_prev = e[0];
          if (last) last_keep_seen = keep;
        end
      end
      if (rvalid) chk("reads_ahead", (issued - consumed) <= 2, 1);
      hold_prev = v & !ready;
      held      = {data, keep, last};
    end
    if (ack && !hold_avail) avail = 1'b0;
  endtask

  task automatic expect_frame(input int size);
    int         nw;
    logic [3:0] lk;
    logic       lb;
    nw = (size + 3) / 4;
    lk = ((size % 4) == 0) ? 4'hF : 4'((1 << (size % 4)) - 1);
    expq.delete();
    for (int i = 0; i < nw; i++) begin
      lb = (i == nw - 1);
      expq.push_back({fmem[i], lb ? lk : 4'hF, lb});
    end
    exp_words  = nw;
    exp_rd_idx = 0;
    issued     = 0;
    consumed   = 0;
    rsize      = 12'(size);
    avail      = 1'b1;
    zero_due   = (size == 0);
  endtask

  task automatic start_frame(input int size);
    chk("size_bound", size <= MTU, 1);
    for (int i = 0; i < 512; i++) fmem[i] = $urandom;
    expect_frame(size);
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n        = 0;
    ack_seen = 1'b0;
    while (!ack_seen && n < 600) begin
      tick();
      n++;
    end
    chk({tag, "_acked"}, ack_seen, 1);
    chk({tag, "_drained"}, expq.size(), 0);
    tick();
  endtask

  initial begin
    int unsigned target;
    int          sz;
    reset_n = 1'b0; avail = 1'b0; rsize = '0; ready = 1'b1; rdata = '0;
    light = 1'b0; hold_avail = 1'b0; ready_mode = 0; cyc = 0; acks = 0;
    prev_rvalid = 1'b0; prev_raddr = '0; hold_prev = 1'b0; held = '0;
    last_xfer_prev = 1'b0; zero_due = 1'b0; exp_count = '0; last_keep_seen = '0;
    exp_words = 0; exp_rd_idx = 0; issued = 0; consumed = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_v", v, 0);
    chk("rst_data", data, 0);
    chk("rst_keep", keep, 0);
    chk("rst_last", last, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Full-word frame with latency checks
    start_frame(64);
    tick();
    chk("lat_t1_rvalid", rvalid, 1);
    chk("lat_t1_v", v, 0);
    tick();
    chk("lat_t2_v", v, 0);
    tick();
    chk("lat_t3_v", v, 1);
    finish_frame("f64");
    chk("count_after_f64", count, 16'd1);
    chk("f64_keep", last_keep_seen, 4'hF);

    start_frame(61);
    finish_frame("f61");
    chk("f61_keep", last_keep_seen, 4'h1);
    start_frame(62);
    finish_frame("f62");
    chk("f62_keep", last_keep_seen, 4'h3);

    start_frame(0);
    finish_frame("zero");
    chk("count_after_zero", count, 16'd4);

    ready_mode = 1;
    start_frame(20);
    finish_frame("bp20");
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      sz = $urandom_range(0, 200);
      start_frame(sz);
      finish_frame("rand");
    end
    ready_mode = 0;

    // Reset in the middle of a 64-byte frame, then re-drain it from word 0
    start_frame(64);
    for (int n = 0; n < 60 && consumed < 3; n++) tick();
    chk("rst_reach_word3", consumed, 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_v", v, 0);
    chk("midrst_data", data, 0);
    chk("midrst_keep", keep, 0);
    chk("midrst_last", last, 0);
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_ack", ack, 0);
    exp_count = '0; prev_rvalid = 1'b0; hold_prev = 1'b0;
    last_xfer_prev = 1'b0; zero_due = 1'b0;
    expq.delete();
    exp_words = 0; exp_rd_idx = 0; issued = 0; consumed = 0;
    tick();
    tick();
    reset_n = 1'b1;
    expect_frame(64);
    finish_frame("redrain");
    chk("count_after_redrain", count, 16'd1);

    // Back-to-back zero-length frames to walk the counter up to its wrap point
    target     = 32'd65535 - 32'(exp_count);
    light      = 1'b1;
    hold_avail = 1'b1;
    acks       = 0;
    rsize      = '0;
    avail      = 1'b1;
    for (int c = 0; c < int'(2 * target + 20) && acks < int'(target); c++) tick();
    avail = 1'b0;
    tick();
    light      = 1'b0;
    hold_avail = 1'b0;
    chk("wrap_acks", acks, target);
    exp_count = exp_count + 16'(target);
    chk("count_ffff", count, 16'hFFFF);
    start_frame(0);
    finish_frame("wrap");
    chk("count_wrapped", count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
